// File: rtl/control_pipe.sv
// control_pipe: RV32I control decoder with registered E/M/W control stages and load-use hazard detection.
module control_pipe #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALUCTRL_WIDTH  = 4,
  parameter int SUPPORT_HALF   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instr_i,
  input  logic                      instr_valid_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      hazard_stall_o,
  output logic [2:0]                d_imm_src_o,
  output logic [ALUCTRL_WIDTH-1:0]  e_alu_ctrl_o,
  output logic                      e_alu_src_b_imm_o,
  output logic                      e_alu_src_a_pc_o,
  output logic                      e_branch_o,
  output logic                      e_jump_o,
  output logic                      e_jalr_o,
  output logic [2:0]                e_funct3_o,
  output logic                      e_illegal_o,
  output logic                      m_mem_read_o,
  output logic                      m_mem_write_o,
  output logic [1:0]                m_mem_size_o,
  output logic                      m_mem_unsigned_o,
  output logic                      m_reg_write_o,
  output logic [REG_ADDR_WIDTH-1:0] m_rd_o,
  output logic                      w_reg_write_o,
  output logic [1:0]                w_result_src_o,
  output logic [REG_ADDR_WIDTH-1:0] w_rd_o
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  logic [6:0] op;
  logic [2:0] f3;
  logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
  logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr, illegal, haz, kill, ok, bad;
  logic [3:0] alu_f, alu_d;
  logic [ALUCTRL_WIDTH-1:0] d_alu;
  logic d_b_imm, d_a_pc, d_br, d_jump, d_jalr, d_ill, d_rd_ld, d_wr, d_rw;
  logic [2:0] d_f3;
  logic [1:0] d_size, d_res, e_res, m_res;
  logic d_uns, e_rd_mr, e_mw, e_uns, e_rw;
  logic [1:0] e_size;
  logic [REG_ADDR_WIDTH-1:0] d_rd, e_rd;
  logic unused;
  assign unused = ^{instr_i[31], instr_i[29:25]};
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign rd = instr_i[7 +: REG_ADDR_WIDTH];
  assign rs1 = instr_i[15 +: REG_ADDR_WIDTH];
  assign rs2 = instr_i[20 +: REG_ADDR_WIDTH];
  assign is_r = op == OP_R;
  assign is_i = op == OP_I;
  assign is_ld = op == OP_LD;
  assign is_st = op == OP_ST;
  assign is_br = op == OP_BR;
  assign is_lui = op == OP_LUI;
  assign is_auipc = op == OP_AUIPC;
  assign is_jal = op == OP_JAL;
  assign is_jalr = op == OP_JALR;
  assign bad = (is_ld && (f3 == 3'b011 || f3[2:1] == 2'b11)) || (is_st && f3 >= 3'b011) ||
               (is_br && f3[2:1] == 2'b01) || ((is_ld || is_st) && f3[1:0] == 2'b01 && SUPPORT_HALF == 0);
  assign illegal = !(is_r || is_i || is_ld || is_st || is_br || is_lui || is_auipc || is_jal || is_jalr) || bad;
  // Load-use: E load whose destination is read by the instruction waiting in D.
  assign haz = e_rd_mr && e_rd != '0 && instr_valid_i &&
               ((!(is_lui || is_auipc || is_jal) && rs1 == e_rd) || ((is_r || is_st || is_br) && rs2 == e_rd));
  assign hazard_stall_o = haz && !flush_i;
  assign kill = flush_i || haz;
  assign ok = instr_valid_i && !illegal && !kill;
  assign d_ill = instr_valid_i && illegal && !kill;
  assign d_imm_src_o = is_st ? 3'b001 : is_br ? 3'b010 : (is_lui || is_auipc) ? 3'b011 : is_jal ? 3'b100 : 3'b000;
  always_comb begin
    case (f3)
      3'b000: alu_f = (is_r && instr_i[30]) ? 4'b0001 : 4'b0000;
      3'b001: alu_f = 4'b1000;
      3'b010: alu_f = 4'b0101;
      3'b011: alu_f = 4'b0110;
      3'b100: alu_f = 4'b0100;
      3'b101: alu_f = instr_i[30] ? 4'b1001 : 4'b0111;
      3'b110: alu_f = 4'b0011;
      default: alu_f = 4'b0010;
    endcase
    alu_d = (is_r || is_i) ? alu_f : (is_ld || is_st) ? 4'b1111 : is_lui ? 4'b1010 : is_br ? 4'b0001 : 4'b0000;
    d_alu = ok ? ALUCTRL_WIDTH'(alu_d) : '0;
  end
  assign d_b_imm = ok && (is_i || is_ld || is_st || is_lui || is_auipc || is_jalr);
  assign d_a_pc = ok && is_auipc;
  assign d_br = ok && is_br;
  assign d_jump = ok && is_jal;
  assign d_jalr = ok && is_jalr;
  assign d_f3 = ok ? f3 : 3'b000;
  assign d_rd_ld = ok && is_ld;
  assign d_wr = ok && is_st;
  assign d_size = ok && (is_ld || is_st) ? f3[1:0] : 2'b00;
  assign d_uns = ok && is_ld && f3[2];
  assign d_rw = ok && (is_r || is_i || is_ld || is_lui || is_auipc || is_jal || is_jalr) && rd != '0;
  assign d_res = !ok ? 2'b00 : is_ld ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
  assign d_rd = ok ? rd : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {e_alu_ctrl_o, e_alu_src_b_imm_o, e_alu_src_a_pc_o, e_branch_o, e_jump_o, e_jalr_o, e_funct3_o, e_illegal_o} <= '0;
      {e_rd_mr, e_mw, e_size, e_uns, e_rw, e_res, e_rd} <= '0;
      {m_mem_read_o, m_mem_write_o, m_mem_size_o, m_mem_unsigned_o, m_reg_write_o, m_res, m_rd_o} <= '0;
      {w_reg_write_o, w_result_src_o, w_rd_o} <= '0;
    end else if (!stall_i) begin
      {e_alu_ctrl_o, e_alu_src_b_imm_o, e_alu_src_a_pc_o, e_branch_o, e_jump_o, e_jalr_o, e_funct3_o, e_illegal_o} <=
        {d_alu, d_b_imm, d_a_pc, d_br, d_jump, d_jalr, d_f3, d_ill};
      {e_rd_mr, e_mw, e_size, e_uns, e_rw, e_res, e_rd} <= {d_rd_ld, d_wr, d_size, d_uns, d_rw, d_res, d_rd};
      {m_mem_read_o, m_mem_write_o, m_mem_size_o, m_mem_unsigned_o, m_reg_write_o, m_res, m_rd_o} <=
        {e_rd_mr, e_mw, e_size, e_uns, e_rw, e_res, e_rd};
      {w_reg_write_o, w_result_src_o, w_rd_o} <= {m_reg_write_o, m_res, m_rd_o};
    end
  end
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed checks of control_pipe decode, staging, hazard, stall and flush behaviour.
module tb_control_pipe;
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] instr = 32'h0;
  logic hazard, e_b_imm, e_a_pc, e_branch, e_jump, e_jalr, e_illegal;
  logic [2:0] imm_src, e_funct3;
  logic [3:0] e_alu;
  logic m_mr, m_mw, m_uns, m_rw, w_rw;
  logic [1:0] m_size, w_res;
  logic [4:0] m_rd, w_rd;
  logic z_hazard, z_b_imm, z_a_pc, z_branch, z_jump, z_jalr, z_illegal;
  logic [2:0] z_imm_src, z_funct3;
  logic [3:0] z_alu;
  logic z_mr, z_mw, z_uns, z_rw, z_wrw;
  logic [1:0] z_size, z_res;
  logic [4:0] z_mrd, z_wrd;
  int n = 0, fails = 0;
  always #5 clk = ~clk;
  control_pipe #(.SUPPORT_HALF(1)) dut (
    .clk(clk), .rst(rst), .instr_i(instr), .instr_valid_i(instr_valid), .stall_i(stall), .flush_i(flush),
    .hazard_stall_o(hazard), .d_imm_src_o(imm_src), .e_alu_ctrl_o(e_alu), .e_alu_src_b_imm_o(e_b_imm),
    .e_alu_src_a_pc_o(e_a_pc), .e_branch_o(e_branch), .e_jump_o(e_jump), .e_jalr_o(e_jalr),
    .e_funct3_o(e_funct3), .e_illegal_o(e_illegal), .m_mem_read_o(m_mr), .m_mem_write_o(m_mw),
    .m_mem_size_o(m_size), .m_mem_unsigned_o(m_uns), .m_reg_write_o(m_rw), .m_rd_o(m_rd),
    .w_reg_write_o(w_rw), .w_result_src_o(w_res), .w_rd_o(w_rd));
  control_pipe #(.SUPPORT_HALF(0)) dut0 (
    .clk(clk), .rst(rst), .instr_i(instr), .instr_valid_i(instr_valid), .stall_i(stall), .flush_i(flush),
    .hazard_stall_o(z_hazard), .d_imm_src_o(z_imm_src), .e_alu_ctrl_o(z_alu), .e_alu_src_b_imm_o(z_b_imm),
    .e_alu_src_a_pc_o(z_a_pc), .e_branch_o(z_branch), .e_jump_o(z_jump), .e_jalr_o(z_jalr),
    .e_funct3_o(z_funct3), .e_illegal_o(z_illegal), .m_mem_read_o(z_mr), .m_mem_write_o(z_mw),
    .m_mem_size_o(z_size), .m_mem_unsigned_o(z_uns), .m_reg_write_o(z_rw), .m_rd_o(z_mrd),
    .w_reg_write_o(z_wrw), .w_result_src_o(z_res), .w_rd_o(z_wrd));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] i, input logic v);
    instr = i;
    instr_valid = v;
    #1;
  endtask
  initial begin
    #1;
    chk("rst_e_alu", 32'(e_alu), 0);
    chk("rst_m_rw", 32'(m_rw), 0);
    chk("rst_w_rw", 32'(w_rw), 0);
    tick; tick;
    rst = 1'b0;
    drive(32'h00500093, 1'b1);
    chk("addi_imm_src", 32'(imm_src), 0);
    chk("rel_e_b_imm", 32'(e_b_imm), 0);
    tick;
    chk("addi_e_alu", 32'(e_alu), 0);
    chk("addi_e_b_imm", 32'(e_b_imm), 1);
    chk("addi_e_illegal", 32'(e_illegal), 0);
    drive(32'h0, 1'b0);
    tick;
    chk("addi_m_rw", 32'(m_rw), 1);
    chk("addi_m_rd", 32'(m_rd), 1);
    tick;
    chk("addi_w_rw", 32'(w_rw), 1);
    chk("addi_w_rd", 32'(w_rd), 1);
    chk("addi_w_res", 32'(w_res), 0);
    drive(32'h0000A103, 1'b1);
    chk("lw_no_haz", 32'(hazard), 0);
    tick;
    drive(32'h002101B3, 1'b1);
    chk("lu_haz", 32'(hazard), 1);
    chk("lw_e_alu", 32'(e_alu), 15);
    tick;
    chk("lu_bubble_alu", 32'(e_alu), 0);
    chk("lu_m_mr", 32'(m_mr), 1);
    chk("lu_m_rd", 32'(m_rd), 2);
    chk("lu_haz_clear", 32'(hazard), 0);
    tick;
    chk("add_e_alu", 32'(e_alu), 0);
    chk("add_e_b_imm", 32'(e_b_imm), 0);
    chk("add_bubble_m_rw", 32'(m_rw), 0);
    chk("lw_w_res", 32'(w_res), 1);
    chk("lw_w_rd", 32'(w_rd), 2);
    drive(32'h0, 1'b0);
    tick;
    chk("add_m_rd", 32'(m_rd), 3);
    drive(32'h00208463, 1'b1);
    chk("beq_imm_src", 32'(imm_src), 2);
    tick;
    chk("beq_e_branch", 32'(e_branch), 1);
    flush = 1'b1;
    drive(32'h40208233, 1'b1);
    tick;
    flush = 1'b0;
    chk("fl_e_branch", 32'(e_branch), 0);
    chk("fl_e_alu", 32'(e_alu), 0);
    chk("fl_m_mr", 32'(m_mr), 0);
    chk("fl_m_mw", 32'(m_mw), 0);
    chk("fl_m_rw", 32'(m_rw), 0);
    drive(32'h0, 1'b0);
    tick;
    chk("beq_w_rw", 32'(w_rw), 0);
    tick;
    chk("sub_never_w", 32'(w_rw), 0);
    drive(32'h0000A103, 1'b1);
    tick;
    flush = 1'b1;
    drive(32'h002101B3, 1'b1);
    chk("flhz_mask", 32'(hazard), 0);
    tick;
    flush = 1'b0;
    chk("flhz_e_alu", 32'(e_alu), 0);
    chk("flhz_m_mr", 32'(m_mr), 1);
    drive(32'h0050A223, 1'b1);
    tick;
    drive(32'h0, 1'b0);
    tick;
    chk("sw_m_mw", 32'(m_mw), 1);
    chk("sw_m_size", 32'(m_size), 2);
    stall = 1'b1;
    drive(32'h00500093, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("st_m_mw", 32'(m_mw), 1);
      chk("st_m_size", 32'(m_size), 2);
      chk("st_e_hold", 32'(e_b_imm), 0);
    end
    stall = 1'b0;
    tick;
    chk("sw_w_rw", 32'(w_rw), 0);
    chk("sw_m_left", 32'(m_mw), 0);
    chk("post_st_e", 32'(e_b_imm), 1);
    drive(32'h0000007F, 1'b1);
    tick;
    chk("bad_op_ill", 32'(e_illegal), 1);
    chk("bad_op_alu", 32'(e_alu), 0);
    chk("bad_op_b_imm", 32'(e_b_imm), 0);
    drive(32'h00009303, 1'b1);
    tick;
    chk("lh0_ill", 32'(z_illegal), 1);
    chk("lh0_alu", 32'(z_alu), 0);
    chk("lh1_ill", 32'(e_illegal), 0);
    drive(32'h0000D303, 1'b1);
    tick;
    chk("lhu0_ill", 32'(z_illegal), 1);
    chk("lh0_m_mr", 32'(z_mr), 0);
    drive(32'h0, 1'b0);
    tick;
    chk("lhu_m_size", 32'(m_size), 1);
    chk("lhu_m_uns", 32'(m_uns), 1);
    chk("lhu_m_mr", 32'(m_mr), 1);
    drive(32'h4020D093, 1'b1);
    tick;
    chk("srai_alu", 32'(e_alu), 9);
    drive(32'h40000093, 1'b1);
    tick;
    chk("addi_b30_alu", 32'(e_alu), 0);
    drive(32'h40208233, 1'b1);
    tick;
    chk("sub_alu", 32'(e_alu), 1);
    drive(32'h000012B7, 1'b1);
    chk("lui_imm_src", 32'(imm_src), 3);
    tick;
    chk("lui_alu", 32'(e_alu), 10);
    drive(32'h0080006F, 1'b1);
    chk("jal_imm_src", 32'(imm_src), 4);
    tick;
    chk("jal_e_jump", 32'(e_jump), 1);
    drive(32'h0, 1'b0);
    tick; tick;
    chk("jal_x0_w_rw", 32'(w_rw), 0);
    chk("jal_w_res", 32'(w_res), 2);
    drive(32'h000100E7, 1'b1);
    tick;
    chk("jalr_e", 32'(e_jalr), 1);
    drive(32'h0, 1'b0);
    tick; tick;
    chk("jalr_w_res", 32'(w_res), 2);
    chk("jalr_w_rw", 32'(w_rw), 1);
    chk("jalr_w_rd", 32'(w_rd), 1);
    drive(32'h00500093, 1'b1);
    tick;
    drive(32'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_e", 32'(e_b_imm), 0);
    chk("mid_rst_m", 32'(m_rw), 0);
    rst = 1'b0;
    tick; tick;
    chk("post_rst_w", 32'(w_rw), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
